// File: rtl/lcv_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcv_mac_pkg
// Description : Shared definitions for the post-MAC accumulation stages:
//               accumulator FSM state encoding, default widths and a helper
//               returning the signed max/min representable at a given width.
// Revision    : 1.0 - initial release
// ============================================================================
package lcv_mac_pkg;

    localparam int c_DEF_IN_WIDTH  = 33;
    localparam int c_DEF_ACC_WIDTH = 48;
    localparam int c_DEF_OUT_WIDTH = 32;
    localparam int c_DEF_CNT_WIDTH = 8;

    // EMPTY: accumulator and term count are zero.
    // ACCUM: at least one non-last term of the current frame absorbed.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;

    // Signed limit of a two's-complement number of 'width' bits (width < 64).
    function automatic logic signed [63:0] sat_limit(input int unsigned width,
                                                     input logic        want_max);
        logic signed [63:0] r_half;
        r_half = 64'sd1 <<< (width - 1);
        if (want_max) return r_half - 64'sd1;
        return -r_half;
    endfunction

endpackage : lcv_mac_pkg
`default_nettype wire

// File: rtl/lcv_sat_narrow.sv
`default_nettype none
// ============================================================================
// Module      : lcv_sat_narrow
// Description : Combinational signed narrowing with saturation.
//               Ports: i_data  - signed input, IN_WIDTH bits (IN_WIDTH < 64)
//                      o_data  - signed result, OUT_WIDTH bits, clamped
//                      o_clamp - high when i_data was outside OUT_WIDTH range
// Revision    : 1.0 - initial release
// ============================================================================
module lcv_sat_narrow
    import lcv_mac_pkg::*;
#(
    parameter int IN_WIDTH  = c_DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = c_DEF_OUT_WIDTH
) (
    input  logic signed [IN_WIDTH-1:0]  i_data,
    output logic        [OUT_WIDTH-1:0] o_data,
    output logic                        o_clamp
);

    localparam int c_PAD = 64 - IN_WIDTH;

    logic signed [63:0] w_wide;
    logic               w_hi;
    logic               w_lo;

    // Widen to 64 bits so the comparison against the package limits is exact.
    assign w_wide = {{c_PAD{i_data[IN_WIDTH-1]}}, i_data};
    assign w_hi   = (w_wide > sat_limit(OUT_WIDTH, 1'b1));
    assign w_lo   = (w_wide < sat_limit(OUT_WIDTH, 1'b0));

    always_comb begin
        o_data = i_data[OUT_WIDTH-1:0];
        if (w_hi) o_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        if (w_lo) o_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end

    assign o_clamp = w_hi | w_lo;

endmodule : lcv_sat_narrow
`default_nettype wire

// File: rtl/lcv_mac_frame_acc.sv
`default_nettype none
// ============================================================================
// Module      : lcv_mac_frame_acc
// Description : Frame accumulator for the signed MAC result stream. Sums the
//               terms of a frame (terminated by s_last) into a wide
//               accumulator and emits a saturated OUT_WIDTH result with a
//               clamp flag and a saturating term count on a valid/ready port.
//               Ports: clk, rst (async, active-low)
//                      s_valid/s_ready/s_data/s_last - input term stream
//                      m_valid/m_ready/m_data/m_sat/m_count - frame result
// Revision    : 1.0 - initial release
// ============================================================================
module lcv_mac_frame_acc
    import lcv_mac_pkg::*;
#(
    parameter int IN_WIDTH  = c_DEF_IN_WIDTH,
    parameter int ACC_WIDTH = c_DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = c_DEF_OUT_WIDTH,
    parameter int CNT_WIDTH = c_DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_sat,
    output logic [CNT_WIDTH-1:0] m_count
);

    acc_state_t                  r_state;
    acc_state_t                  w_state_nxt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_acc_nxt;
    logic signed [ACC_WIDTH-1:0] w_term;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic [CNT_WIDTH-1:0]        w_cnt_nxt;
    logic [CNT_WIDTH-1:0]        w_cnt_inc;
    logic                        w_fire;
    logic                        w_load;
    logic [OUT_WIDTH-1:0]        w_sat_data;
    logic                        w_sat_clamp;

    // rst gating keeps the input closed during reset even though m_valid is
    // already cleared asynchronously.
    assign s_ready   = rst & (~m_valid | m_ready);
    assign w_fire    = s_valid & s_ready;

    assign w_term    = {{(ACC_WIDTH-IN_WIDTH){s_data[IN_WIDTH-1]}}, s_data};
    assign w_sum     = r_acc + w_term;
    assign w_cnt_inc = (r_cnt == {CNT_WIDTH{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    lcv_sat_narrow #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat (
        .i_data  (w_sum),
        .o_data  (w_sat_data),
        .o_clamp (w_sat_clamp)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;

        if (w_fire) begin
            if (s_last) begin
                w_load    = 1'b1;
                w_acc_nxt = '0;
                w_cnt_nxt = '0;
            end else begin
                w_acc_nxt = w_sum;
                w_cnt_nxt = w_cnt_inc;
            end
        end

        case (r_state)
            ST_EMPTY: if (w_fire && !s_last) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_fire &&  s_last) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A load takes priority over a consume so back-to-back frames see no
    // bubble; payload registers only change on a load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
            m_count <= '0;
        end else if (w_load) begin
            m_valid <= 1'b1;
            m_data  <= w_sat_data;
            m_sat   <= w_sat_clamp;
            m_count <= w_cnt_inc;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule : lcv_mac_frame_acc
`default_nettype wire

// File: tb/tb_lcv_mac_frame_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcv_mac_frame_acc
// Description : Self-checking bench for lcv_mac_frame_acc. A behavioural
//               model (64-bit integer frame sums, result slot) predicts
//               handshake and result values every cycle; directed frames
//               cover saturation, backpressure, count saturation and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcv_mac_frame_acc;

    localparam int c_IN  = 33;
    localparam int c_OUT = 32;
    localparam int c_CNT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [c_IN-1:0]   s_data = '0;
    logic              s_last = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [c_OUT-1:0]  m_data;
    logic              m_sat;
    logic [c_CNT-1:0]  m_count;

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_mode = 0;   // 0: m_ready held high, 1: random, 2: driven directly

    // Model state: running frame sum/term count and the pending result slot.
    longint     mdl_sum  = 0;
    int         mdl_cnt  = 0;
    bit         mdl_pend = 1'b0;
    logic [31:0] mdl_data = '0;
    bit         mdl_sat  = 1'b0;
    int         mdl_count = 0;

    lcv_mac_frame_acc dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sat   (m_sat),
        .m_count (m_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [c_IN-1:0] d);
        logic signed [c_IN-1:0] t;
        t = d;
        return longint'(t);
    endfunction

    // Check everything at the falling edge, then advance the model to what
    // the coming rising edge must produce.
    always @(negedge clk) begin
        bit exp_ready;
        if (!rst) begin
            mdl_sum = 0; mdl_cnt = 0; mdl_pend = 1'b0;
            mdl_data = '0; mdl_sat = 1'b0; mdl_count = 0;
            chk("s_ready_in_reset", s_ready, 0);
            chk("m_valid_in_reset", m_valid, 0);
        end else begin
            exp_ready = !mdl_pend || m_ready;
            chk("s_ready", s_ready, exp_ready);
            chk("m_valid", m_valid, mdl_pend);
            if (mdl_pend) begin
                chk("m_data",  m_data,  mdl_data);
                chk("m_sat",   m_sat,   mdl_sat);
                chk("m_count", m_count, mdl_count);
            end
            if (s_valid && exp_ready) begin
                mdl_sum += sx(s_data);
                mdl_cnt++;
                if (s_last) begin
                    if (mdl_sum > 64'sd2147483647) begin
                        mdl_data = 32'h7FFF_FFFF; mdl_sat = 1'b1;
                    end else if (mdl_sum < -64'sd2147483648) begin
                        mdl_data = 32'h8000_0000; mdl_sat = 1'b1;
                    end else begin
                        mdl_data = 32'(mdl_sum); mdl_sat = 1'b0;
                    end
                    mdl_count = (mdl_cnt > 255) ? 255 : mdl_cnt;
                    mdl_pend  = 1'b1;
                    mdl_sum   = 0;
                    mdl_cnt   = 0;
                end else if (mdl_pend && m_ready) begin
                    mdl_pend = 1'b0;
                end
            end else if (mdl_pend && m_ready) begin
                mdl_pend = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) m_ready = 1'b1;
            else if (rdy_mode == 1) m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Offer one term and hold it until it is accepted (bounded wait).
    task automatic send(input logic [c_IN-1:0] d, input bit l);
        bit acc;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int g = 0; g < 2000; g++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #2;
            if (acc) begin
                s_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [c_IN-1:0] rnd_term();
        case ($urandom_range(0, 4))
            0: return c_IN'(33'($urandom_range(0, 2000)) - 33'd1000);
            1: return 33'h0_7FFF_FFFF;
            2: return 33'h1_0000_0000;
            3: return {1'($urandom_range(0, 1)), 32'($urandom)};
            default: return 33'h1_FFFF_FFFF;
        endcase
    endfunction

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_data",  m_data,  0);
        chk("rst_m_sat",   m_sat,   0);
        chk("rst_m_count", m_count, 0);
        rst = 1'b1;
        #1;
        chk("release_s_ready", s_ready, 1);

        // 3-term frame
        send(33'd5, 0); send(-33'sd2, 0); send(33'd10, 1);
        @(negedge clk);
        chk("frame3_valid", m_valid, 1);
        chk("frame3_data",  m_data,  32'd13);
        chk("frame3_count", m_count, 3);
        @(posedge clk); #2;

        // Consecutive single-term frames: 0x7FFF_FFFF then -1
        send(33'h0_7FFF_FFFF, 1); send(33'h1_FFFF_FFFF, 1);
        idle(2);

        // Positive and negative overflow
        for (int i = 0; i < 4; i++) send(33'h0_7FFF_FFFF, i == 3);
        for (int i = 0; i < 3; i++) send(33'h1_0000_0000, i == 2);
        idle(2);

        // Backpressure with a new last beat offered while blocked
        rdy_mode = 2;
        m_ready  = 1'b0;
        send(33'd5, 1);
        s_valid = 1'b1; s_data = 33'd9; s_last = 1'b0;
        idle(0);
        s_valid = 1'b1;
        repeat (3) begin @(posedge clk); #2; end
        chk("bp_s_ready", s_ready, 0);
        chk("bp_hold", m_data, 32'd5);
        s_data = 33'd7; s_last = 1'b1;
        m_ready = 1'b1;
        send(33'd7, 1);
        @(negedge clk);
        chk("bp_new_result", m_data, 32'd7);
        rdy_mode = 0;
        idle(2);

        // Long frame: count saturates
        for (int i = 0; i < 300; i++) send(33'd1, i == 299);
        @(negedge clk);
        chk("long_data",  m_data,  32'd300);
        chk("long_count", m_count, 255);
        idle(2);

        // Reset mid-frame discards partial sum
        send(33'd100, 0); send(33'd200, 0);
        rst = 1'b0;
        #1;
        chk("async_clear_valid", m_valid, 0);
        idle(2);
        rst = 1'b1;
        send(33'd1, 1);
        @(negedge clk);
        chk("post_rst_data",  m_data,  32'd1);
        chk("post_rst_count", m_count, 1);
        idle(2);

        // Randomized frames with random gaps and random backpressure
        rdy_mode = 1;
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int t = 0; t < len; t++) begin
                send(rnd_term(), t == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rdy_mode = 0;
        idle(4);
        chk("drained", m_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_lcv_mac_frame_acc
`default_nettype wire
